// File: rtl/scarv_cop_mem_seq.sv
// Load/store sequencer for the SCARV coprocessor: one memory transaction at a time, 1/2/4 beats.
// Define SCARV_COP_SG_EN to enable the scatter/gather subclasses.
module scarv_cop_mem_seq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        insn_valid,
    output logic        insn_ready,
    input  logic [3:0]  insn_sclass,
    input  logic [31:0] insn_base,
    input  logic [31:0] insn_imm,
    input  logic [31:0] insn_offs,
    input  logic [31:0] insn_wdata,
    input  logic        insn_wb_h,
    input  logic        insn_wb_b,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_ben,
    input  logic        mem_recv,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_error
);
    localparam logic [3:0] SCLASS_SCATTER_B = 4'h0;
    localparam logic [3:0] SCLASS_SCATTER_H = 4'h1;
    localparam logic [3:0] SCLASS_GATHER_B  = 4'h2;
    localparam logic [3:0] SCLASS_GATHER_H  = 4'h3;
    localparam logic [3:0] SCLASS_LD_BU     = 4'h4;
    localparam logic [3:0] SCLASS_LD_HU     = 4'h5;
    localparam logic [3:0] SCLASS_LD_W      = 4'h6;
    localparam logic [3:0] SCLASS_ST_B      = 4'h7;
    localparam logic [3:0] SCLASS_ST_H      = 4'h8;
    localparam logic [3:0] SCLASS_ST_W      = 4'h9;

`ifdef SCARV_COP_SG_EN
    localparam bit SG_EN = 1'b1;
`else
    localparam bit SG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_reg;
    logic [3:0]  sclass_reg;
    logic [31:0] base_reg, imm_reg, offs_reg, wdata_reg;
    logic        wb_h_reg, wb_b_reg;
    logic [1:0]  beat_reg;

    logic        size_w, size_h, size_b, is_store, is_sg, known;
    logic [1:0]  beats_m1;

    always_comb begin
        size_w   = 1'b0;
        size_h   = 1'b0;
        size_b   = 1'b0;
        is_store = 1'b0;
        is_sg    = 1'b0;
        known    = 1'b1;
        beats_m1 = 2'd0;
        case (sclass_reg)
            SCLASS_LD_W:      size_w = 1'b1;
            SCLASS_LD_HU:     size_h = 1'b1;
            SCLASS_LD_BU:     size_b = 1'b1;
            SCLASS_ST_W:      begin size_w = 1'b1; is_store = 1'b1; end
            SCLASS_ST_H:      begin size_h = 1'b1; is_store = 1'b1; end
            SCLASS_ST_B:      begin size_b = 1'b1; is_store = 1'b1; end
            SCLASS_GATHER_H:  begin size_h = 1'b1; is_sg = 1'b1; beats_m1 = 2'd1; end
            SCLASS_GATHER_B:  begin size_b = 1'b1; is_sg = 1'b1; beats_m1 = 2'd3; end
            SCLASS_SCATTER_H: begin size_h = 1'b1; is_sg = 1'b1; is_store = 1'b1; beats_m1 = 2'd1; end
            SCLASS_SCATTER_B: begin size_b = 1'b1; is_sg = 1'b1; is_store = 1'b1; beats_m1 = 2'd3; end
            default:          known = 1'b0;
        endcase
        if (is_sg && !SG_EN) begin
            known = 1'b0;
        end
    end

    // Scatter/gather elements follow the beat index; single-beat ops use the wb lane select.
    logic        lane_h;
    logic [1:0]  lane_b;
    logic [7:0]  off_b, st_byte, rd_byte;
    logic [15:0] off_h, st_half, rd_half;
    logic [31:0] beat_addr, beat_wdata;
    logic [3:0]  beat_ben;
    logic        misaligned, beat_last, issue;

    assign lane_h  = is_sg ? beat_reg[0] : wb_h_reg;
    assign lane_b  = is_sg ? beat_reg : {wb_h_reg, wb_b_reg};
    assign off_b   = offs_reg[{beat_reg, 3'b000} +: 8];
    assign off_h   = offs_reg[{beat_reg[0], 4'b0000} +: 16];
    assign st_byte = wdata_reg[{lane_b, 3'b000} +: 8];
    assign st_half = wdata_reg[{lane_h, 4'b0000} +: 16];
    assign rd_byte = mem_rdata[{beat_addr[1:0], 3'b000} +: 8];
    assign rd_half = mem_rdata[{beat_addr[1], 4'b0000} +: 16];

    assign beat_addr = !is_sg ? base_reg + imm_reg :
                       size_b ? base_reg + {24'd0, off_b} :
                                base_reg + {16'd0, off_h};
    assign beat_wdata = size_w ? wdata_reg : size_h ? {2{st_half}} : {4{st_byte}};
    assign beat_ben   = size_w ? 4'b1111 :
                        size_h ? (beat_addr[1] ? 4'b1100 : 4'b0011) :
                                 (4'b0001 << beat_addr[1:0]);
    assign misaligned = (size_w && beat_addr[1:0] != 2'b00) || (size_h && beat_addr[0]);
    assign beat_last  = SG_EN ? (beat_reg == beats_m1) : 1'b1;

    // Request fields are held by the captured registers, so they are stable until grant.
    assign issue     = (state_reg == REQ) && known && !misaligned;
    assign mem_req   = issue;
    assign mem_wen   = issue && is_store;
    assign mem_addr  = issue ? beat_addr : 32'd0;
    assign mem_wdata = issue ? beat_wdata : 32'd0;
    assign mem_ben   = issue ? beat_ben : 4'd0;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg  <= IDLE;
            sclass_reg <= 4'd0;
            base_reg   <= 32'd0;
            imm_reg    <= 32'd0;
            offs_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            wb_h_reg   <= 1'b0;
            wb_b_reg   <= 1'b0;
            beat_reg   <= 2'd0;
            insn_ready <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_error  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (insn_valid) begin
                        sclass_reg <= insn_sclass;
                        base_reg   <= insn_base;
                        imm_reg    <= insn_imm;
                        offs_reg   <= insn_offs;
                        wdata_reg  <= insn_wdata;
                        wb_h_reg   <= insn_wb_h;
                        wb_b_reg   <= insn_wb_b;
                        beat_reg   <= 2'd0;
                        res_data   <= insn_wdata;
                        res_error  <= 1'b0;
                        insn_ready <= 1'b0;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (!known || misaligned) begin
                        res_error <= 1'b1;
                        res_data  <= 32'd0;
                        res_valid <= 1'b1;
                        state_reg <= DONE;
                    end else if (mem_gnt) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_error) begin
                        res_error <= 1'b1;
                        res_data  <= 32'd0;
                        res_valid <= 1'b1;
                        state_reg <= DONE;
                    end else if (mem_recv) begin
                        if (!is_store) begin
                            if (size_w) begin
                                res_data <= mem_rdata;
                            end else if (size_h) begin
                                res_data[{lane_h, 4'b0000} +: 16] <= rd_half;
                            end else begin
                                res_data[{lane_b, 3'b000} +: 8] <= rd_byte;
                            end
                        end
                        if (beat_last) begin
                            if (is_store) begin
                                res_data <= 32'd0;
                            end
                            res_valid <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            beat_reg  <= beat_reg + 2'd1;
                            state_reg <= REQ;
                        end
                    end
                end
                DONE: begin
                    insn_ready <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scarv_cop_mem_seq.sv
// Scoreboard bench for scarv_cop_mem_seq: random load/store traffic against a byte-level reference model.
module tb_scarv_cop_mem_seq;
    localparam logic [3:0] SC_SCATTER_B = 4'h0;
    localparam logic [3:0] SC_SCATTER_H = 4'h1;
    localparam logic [3:0] SC_GATHER_B  = 4'h2;
    localparam logic [3:0] SC_GATHER_H  = 4'h3;
    localparam logic [3:0] SC_LD_BU     = 4'h4;
    localparam logic [3:0] SC_LD_HU     = 4'h5;
    localparam logic [3:0] SC_LD_W      = 4'h6;
    localparam logic [3:0] SC_ST_B      = 4'h7;
    localparam logic [3:0] SC_ST_H      = 4'h8;
    localparam logic [3:0] SC_ST_W      = 4'h9;

`ifdef SCARV_COP_SG_EN
    localparam bit SG = 1'b1;
`else
    localparam bit SG = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        insn_valid = 1'b0;
    logic        insn_ready;
    logic [3:0]  insn_sclass = 4'd0;
    logic [31:0] insn_base = 32'd0, insn_imm = 32'd0, insn_offs = 32'd0, insn_wdata = 32'd0;
    logic        insn_wb_h = 1'b0, insn_wb_b = 1'b0;
    logic        mem_req, mem_wen;
    logic        mem_gnt = 1'b0, mem_recv = 1'b0, mem_error = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  mem_ben;
    logic        res_valid, res_error;
    logic [31:0] res_data;

    scarv_cop_mem_seq dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_sclass(insn_sclass),
        .insn_base(insn_base), .insn_imm(insn_imm), .insn_offs(insn_offs),
        .insn_wdata(insn_wdata), .insn_wb_h(insn_wb_h), .insn_wb_b(insn_wb_b),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_recv(mem_recv), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .res_valid(res_valid), .res_data(res_data), .res_error(res_error)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; bit err; } exp_t;
    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] ben; } req_t;
    exp_t exp_q[$];
    req_t req_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Memory content: explicit overrides, otherwise a fixed hash of the address.
    bit [7:0] ov [bit [31:0]];
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        if (ov.exists(a)) return ov[a];
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
    endfunction

    // Reference model: derives requests and result from sizes, lanes and byte arithmetic.
    task automatic model(input logic [3:0] sc, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] offs, input logic [31:0] wdata,
                         input logic wbh, input logic wbb, input int eb);
        int n, sz, lane;
        bit st, sg, ok, stop;
        exp_t e;
        req_t r;
        logic [31:0] res, a, val, mask;
        ok = 1; sg = 0; st = 0; n = 1; sz = 4; stop = 0;
        case (sc)
            SC_LD_W:      sz = 4;
            SC_LD_HU:     sz = 2;
            SC_LD_BU:     sz = 1;
            SC_ST_W:      begin sz = 4; st = 1; end
            SC_ST_H:      begin sz = 2; st = 1; end
            SC_ST_B:      begin sz = 1; st = 1; end
            SC_GATHER_H:  begin sz = 2; sg = 1; n = 2; end
            SC_GATHER_B:  begin sz = 1; sg = 1; n = 4; end
            SC_SCATTER_H: begin sz = 2; sg = 1; n = 2; st = 1; end
            SC_SCATTER_B: begin sz = 1; sg = 1; n = 4; st = 1; end
            default:      ok = 0;
        endcase
        if (sg && !SG) ok = 0;
        e.err = !ok;
        res = st ? 32'd0 : wdata;
        if (ok) begin
            for (int i = 0; i < n && !stop; i++) begin
                if (!sg)          a = base + imm;
                else if (sz == 1) a = base + ((offs >> (8 * i)) & 32'hFF);
                else              a = base + ((offs >> (16 * i)) & 32'hFFFF);
                if (a % sz != 0) begin
                    e.err = 1; stop = 1;
                end else begin
                    if (sz == 4)      lane = 0;
                    else if (sg)      lane = i;
                    else if (sz == 2) lane = int'(wbh);
                    else              lane = int'({wbh, wbb});
                    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
                    val = (wdata >> (8 * sz * lane)) & mask;
                    r.addr  = a;
                    r.wen   = st;
                    r.ben   = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << (a % 4));
                    r.wdata = (sz == 4) ? wdata : (sz == 2) ? val * 32'h0001_0001 : val * 32'h0101_0101;
                    req_q.push_back(r);
                    if (i == eb) begin
                        e.err = 1; stop = 1;
                    end else if (!st) begin
                        val = 0;
                        for (int k = 0; k < sz; k++) val |= 32'(mbyte(a + k)) << (8 * k);
                        res = (res & ~(mask << (8 * sz * lane))) | (val << (8 * sz * lane));
                    end
                end
            end
        end
        e.data = res;
        exp_q.push_back(e);
    endtask

    // Memory responder: checks each request, optional stall before grant, returns data or error.
    int stall_cycles = 0;
    bit rand_delays = 0;
    int err_beat = -1;
    int beat_idx = 0;
    bit hold_resp = 0;
    int req_cycles = 0;
    req_t rsp_r;
    logic [31:0] rsp_a0, rsp_aw;
    int rsp_d;

    always @(negedge g_clk) if (mem_req) req_cycles <= req_cycles + 1;

    initial begin
        forever begin
            @(negedge g_clk);
            if (g_resetn && mem_req) begin
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
                end else begin
                    rsp_r = req_q.pop_front();
                    check("req_addr", mem_addr, rsp_r.addr);
                    check1("req_wen", mem_wen, rsp_r.wen);
                    check("req_ben", {28'd0, mem_ben}, {28'd0, rsp_r.ben});
                    if (rsp_r.wen) check("req_wdata", mem_wdata, rsp_r.wdata);
                end
                rsp_a0 = mem_addr;
                rsp_d = rand_delays ? int'($urandom_range(0, 2)) : stall_cycles;
                for (int k = 0; k < rsp_d; k++) begin
                    @(negedge g_clk);
                    check1("stall_req", mem_req, 1'b1);
                    check("stall_addr", mem_addr, rsp_a0);
                end
                mem_gnt = 1'b1;
                @(posedge g_clk); #1;
                mem_gnt = 1'b0;
                if (hold_resp) begin
                    while (hold_resp) @(negedge g_clk);
                    mem_rdata = 32'hBAD0_BAD0;
                    mem_recv = 1'b1;
                    @(posedge g_clk); #1;
                    mem_recv = 1'b0;
                end else begin
                    rsp_d = rand_delays ? int'($urandom_range(0, 2)) : 0;
                    repeat (rsp_d) begin @(posedge g_clk); #1; end
                    rsp_aw = rsp_a0 & ~32'd3;
                    mem_rdata = {mbyte(rsp_aw + 3), mbyte(rsp_aw + 2), mbyte(rsp_aw + 1), mbyte(rsp_aw)};
                    if (beat_idx == err_beat) mem_error = 1'b1;
                    else mem_recv = 1'b1;
                    beat_idx++;
                    @(posedge g_clk); #1;
                    mem_recv = 1'b0;
                    mem_error = 1'b0;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every res_valid.
    int res_cnt = 0;
    logic [31:0] last_data = 32'd0;
    logic last_err = 1'b0;
    int last_cyc = 0;
    bit ready_chk = 0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge g_clk);
            if (ready_chk) begin
                check1("ready_after_res", insn_ready, 1'b1);
                ready_chk = 0;
            end
            if (res_valid) begin
                check1("ready_low_in_done", insn_ready, 1'b0);
                res_cnt++;
                last_data = res_data;
                last_err = res_error;
                last_cyc = cyc;
                ready_chk = 1;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_res: got res_valid data %h expected none", res_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check1("res_error", res_error, mon_e.err);
                    if (!mon_e.err) check("res_data", res_data, mon_e.data);
                    $display("[TB] result %0d: data=%h error=%0d", res_cnt, res_data, res_error);
                end
            end
        end
    end

    int acc_cyc = 0;

    task automatic issue(input logic [3:0] sc, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] offs, input logic [31:0] wdata,
                         input logic wbh, input logic wbb, input int eb, input bit expect_done);
        int guard, start;
        model(sc, base, imm, offs, wdata, wbh, wbb, eb);
        if (!expect_done) void'(exp_q.pop_back());
        err_beat = eb;
        beat_idx = 0;
        guard = 0;
        @(negedge g_clk);
        while (!insn_ready && guard < 100) begin @(negedge g_clk); guard++; end
        if (guard >= 100) begin tests++; fails++; $display("FAIL ready_timeout: got ready 0 expected 1"); end
        start = res_cnt;
        acc_cyc = cyc;
        insn_sclass = sc; insn_base = base; insn_imm = imm; insn_offs = offs;
        insn_wdata = wdata; insn_wb_h = wbh; insn_wb_b = wbb; insn_valid = 1'b1;
        @(posedge g_clk); #1;
        insn_valid = 1'b0;
        insn_sclass = 4'($urandom); insn_base = $urandom; insn_imm = $urandom;
        insn_offs = $urandom; insn_wdata = $urandom;
        if (expect_done) begin
            guard = 0;
            while (res_cnt == start && guard < 300) begin @(negedge g_clk); guard++; end
            if (guard >= 300) begin tests++; fails++; $display("FAIL res_timeout: got no res_valid expected one"); end
            check("req_q_drained", 32'(req_q.size()), 32'd0);
        end
    endtask

    int rc;
    logic [3:0] r_sc;
    logic [31:0] r_base, r_offs;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check1("rst_insn_ready", insn_ready, 1'b1);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_ben", {28'd0, mem_ben}, 32'd0);
        check1("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        check1("rst_res_error", res_error, 1'b0);
        #1 g_resetn = 1'b1;

        ov[32'h1004] = 8'hEF; ov[32'h1005] = 8'hBE; ov[32'h1006] = 8'hAD; ov[32'h1007] = 8'hDE;
        ov[32'h2000] = 8'h11; ov[32'h2001] = 8'h22; ov[32'h2002] = 8'h33; ov[32'h2003] = 8'h44;

        rc = req_cycles;
        issue(SC_LD_W, 32'h1000, 32'd4, 32'd0, 32'h0, 1'b0, 1'b0, -1, 1'b1);
        check("ldw_data", last_data, 32'hDEAD_BEEF);
        check1("ldw_err", last_err, 1'b0);
        check("ldw_latency", 32'(last_cyc - acc_cyc), 32'd3);
        check("ldw_req_cycles", 32'(req_cycles - rc), 32'd1);

        rc = req_cycles;
        issue(SC_GATHER_B, 32'h2000, 32'd0, 32'h0302_0100, 32'h5555_5555, 1'b0, 1'b0, -1, 1'b1);
        if (SG) begin
            check("gatherb_data", last_data, 32'h4433_2211);
            check("gatherb_req_cycles", 32'(req_cycles - rc), 32'd4);
        end else begin
            check1("gatherb_nosg_err", last_err, 1'b1);
            check("gatherb_nosg_req_cycles", 32'(req_cycles - rc), 32'd0);
        end

        rc = req_cycles;
        issue(SC_ST_H, 32'h3001, 32'd0, 32'd0, 32'h1234_5678, 1'b1, 1'b0, -1, 1'b1);
        check1("sth_misalign_err", last_err, 1'b1);
        check("sth_misalign_req_cycles", 32'(req_cycles - rc), 32'd0);

        rc = req_cycles;
        issue(SC_SCATTER_H, 32'h4000, 32'd0, 32'h0010_0004, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 1'b1);
        check1("scatterh_err", last_err, 1'b1);
        check("scatterh_req_cycles", 32'(req_cycles - rc), SG ? 32'd1 : 32'd0);

        stall_cycles = 5;
        rc = req_cycles;
        issue(SC_LD_W, 32'h1000, 32'd4, 32'd0, 32'h0, 1'b0, 1'b0, -1, 1'b1);
        check("stall_req_cycles", 32'(req_cycles - rc), 32'd6);
        check("stall_data", last_data, 32'hDEAD_BEEF);
        stall_cycles = 0;

        hold_resp = 1'b1;
        issue(SC_LD_W, 32'h5000, 32'd8, 32'd0, 32'h0, 1'b0, 1'b0, -1, 1'b0);
        @(posedge g_clk); #3;
        g_resetn = 1'b0;
        #1;
        check1("midrst_ready", insn_ready, 1'b1);
        check1("midrst_req", mem_req, 1'b0);
        @(posedge g_clk); #2;
        g_resetn = 1'b1;
        rc = res_cnt;
        hold_resp = 1'b0;
        repeat (6) @(negedge g_clk);
        check("midrst_no_res", 32'(res_cnt), 32'(rc));
        check1("midrst_ready_after", insn_ready, 1'b1);

        rand_delays = 1'b1;
        for (int t = 0; t < 200; t++) begin
            r_sc = 4'($urandom_range(0, 11));
            r_base = $urandom;
            if ($urandom_range(0, 1) == 1) r_base[1:0] = 2'b00;
            r_offs = $urandom;
            if ($urandom_range(0, 1) == 1) r_offs = r_offs & 32'hFCFC_FCFC;
            issue(r_sc, r_base, 32'($urandom_range(0, 8)), r_offs, $urandom,
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b1);
        end
        repeat (3) @(negedge g_clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
